odd_rf_stage: RTL
=================

Name: odd_rf_stage

Overview:
Register-fetch stage feeding the odd pipe (permute / local-store / branch). It holds the 128 x 128-bit register file, which is written by both the even and odd write-back ports. Each cycle it resolves up to three source operands, bypassing from in-flight even/odd pipe stages and from write-back. It detects RAW hazards against results that are not yet ready and stalls the upstream decode stage. It registers the resolved operands and control fields into the odd pipe's input.

Parameters:
NUM_REGS, 128, register count (address 7 bits)
DATA_W, 128, register width
PACK_W, 143, packed stage word width: [0:2] unit_id, [3:130] result, [131:137] reg_dst, [138:141] latency, [142] reg_wr
FWD_STAGES, 7, forwarding stages per pipe

Ports:
clk  in  1  clock
rst  in  1  reset
id_valid  in  1  decode slot holds an instruction
id_instr_id  in  7  instruction ID
id_unit_id  in  3  unit ID
id_latency  in  4  result latency in stages
id_reg_wr  in  1  instruction writes rt
id_reg_dst  in  7  destination register
id_ra_addr / id_rb_addr / id_rc_addr  in  7 each  source addresses
id_src_used  in  3  [0]=ra, [1]=rb, [2]=rc operand used
id_imm  in  18  immediate, passed through
id_pc  in  10  PC, passed through
stall  out  1  upstream holds all id_* stable this cycle
even_fwd / odd_fwd  in  FWD_STAGES*PACK_W each  stage k (1..7) at bits [(k-1)*PACK_W : k*PACK_W-1]
even_wb_en / odd_wb_en  in  1 each  write-back enable
even_wb_addr / odd_wb_addr  in  7 each  write-back address
even_wb_data / odd_wb_data  in  128 each  write-back data
ex_valid, ex_instr_id, ex_unit_id, ex_latency, ex_reg_wr, ex_reg_dst, ex_imm, ex_pc  out  registered copies of id_* fields (same widths)
ex_ra_data / ex_rb_data / ex_rc_data  out  128 each  resolved operands

Behaviour:
- Reset: asynchronous, active-high; clock clk.
  - All ex_* outputs clear to 0 and all registers clear to 0.
  - Reset mid-operation discards any in-flight bubble or instruction.
- Register file:
  - Written at posedge from both WB ports.
  - When both ports write the same address, odd data wins.
- Operand resolution (per source, combinational), priority from youngest to oldest:
  - even stage1, odd stage1, even stage2, … odd stage7, then WB ports, then the RF array.
  - Within one stage, odd wins over even.
- Stage match:
  - A stage matches when reg_wr=1 and reg_dst equals the source address.
  - Only the youngest match is considered.
  - If stage index k >= latency (latency 0 counts as ready), its result [3:130] is forwarded.
  - If k < latency, that source is a hazard.
- WB match: wb_en=1 and address equal; data is bypassed in the same cycle the write occurs.
- Unused sources (id_src_used bit 0) never cause a hazard; their data is whatever resolves.
- stall = id_valid AND (any used source is a hazard). Purely combinational, no registered state.
- Posedge, not reset:
  - If id_valid=1 and stall=0: load all ex_* from id_* and resolved data; ex_valid=1.
  - Otherwise: load a bubble, all ex_* = 0 (so ex_reg_wr=0 and ex_valid=0).
- Latency: operands appear on ex_* one cycle after the accepting edge. Back-to-back accepts at 1 instruction per cycle.
- A stalled instruction is retried every cycle. It is accepted on the first cycle its producer reaches stage k >= latency; no extra bubble.

Decomposition:
- spu_pkg (shared):
  - PACK_W and packed field offsets (UNIT_LO=0, RES_LO=3, DST_LO=131, LAT_LO=138, WR_BIT=142).
  - Unit ID codes (perm 3'b100, LS 3'b101, branch 3'b110).
  - Instruction ID defines.
- Sub-module operand_resolver: one source's stage scan plus WB/RF select. Outputs data and hazard. Instantiated three times.

Test Plan:
1. Reset, then WB odd r5 = 0xA5…A5, then read ra=5 with id_src_used=001 -> next cycle ex_ra_data=0xA5…A5, ex_valid=1, stall=0.
2. Odd stage3 holds {reg_dst=9, latency=2, reg_wr=1, result=0x1234}, and the RF holds r9=0 -> ex_rb_data=0x…1234.
3. Even stage2 holds {reg_dst=9, latency=6, reg_wr=1}, rc=9 used -> stall=1 for 4 cycles as the producer advances to stage 6, then accepted. Bubbles (ex_valid=0, ex_reg_wr=0) appear during the stall; the producer's result is forwarded on accept.
4. Same hazard as scenario 3 but id_src_used=000 -> stall=0, instruction accepted immediately.
5. Even and odd WB both write r20 (even 0x1, odd 0x2) while reading r20 -> ex data=0x2, and the RF holds 0x2 afterwards.
6. Assert rst while an instruction is stalled -> all ex_* = 0 immediately and RF cleared. After release, id_valid=0 yields bubbles.

Source files
------------

// File: rtl/odd_rf_stage_pkg.sv
// ============================================================================
//  Module   : odd_rf_stage_pkg
//  Purpose  : Shared constants, packed-word layout and types for the odd-pipe
//             register-fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package odd_rf_stage_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 128;
    localparam int NUM_REGS   = 128;
    localparam int PACK_W     = 143;
    localparam int FWD_STAGES = 7;
    localparam int LAT_W      = 4;

    // Forwarding word layout: {reg_wr, latency, reg_dst, result, unit_id}
    localparam int UNIT_LO = 0;
    localparam int RES_LO  = 3;
    localparam int DST_LO  = 131;
    localparam int LAT_LO  = 138;
    localparam int WR_BIT  = 142;

    typedef enum logic [2:0] {
        UNIT_NONE = 3'b000,
        UNIT_PERM = 3'b100,
        UNIT_LS   = 3'b101,
        UNIT_BR   = 3'b110
    } unit_e;

    localparam logic [6:0] IID_NOP   = 7'h00;
    localparam logic [6:0] IID_SHUFB = 7'h01;
    localparam logic [6:0] IID_LQD   = 7'h02;
    localparam logic [6:0] IID_STQD  = 7'h03;
    localparam logic [6:0] IID_BR    = 7'h04;

    typedef struct packed {
        logic              valid;
        logic [6:0]        instr_id;
        logic [2:0]        unit_id;
        logic [LAT_W-1:0]  latency;
        logic              reg_wr;
        logic [ADDR_W-1:0] reg_dst;
        logic [17:0]       imm;
        logic [9:0]        pc;
        logic [DATA_W-1:0] ra_data;
        logic [DATA_W-1:0] rb_data;
        logic [DATA_W-1:0] rc_data;
    } ex_word_t;

    // A producer sitting in stage k has its result once k has caught up with its latency.
    function automatic logic stage_ready(input int k, input logic [LAT_W-1:0] lat);
        return k >= int'(lat);
    endfunction

endpackage

`default_nettype wire

// File: rtl/odd_rf_stage_if.sv
// ============================================================================
//  Module   : odd_rf_stage_if
//  Purpose  : Decode-side issue slot, stall back-pressure and odd-pipe input
//             fields of the register-fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface odd_rf_stage_if;
    logic         id_valid;
    logic [6:0]   id_instr_id;
    logic [2:0]   id_unit_id;
    logic [3:0]   id_latency;
    logic         id_reg_wr;
    logic [6:0]   id_reg_dst;
    logic [6:0]   id_ra_addr;
    logic [6:0]   id_rb_addr;
    logic [6:0]   id_rc_addr;
    logic [2:0]   id_src_used;
    logic [17:0]  id_imm;
    logic [9:0]   id_pc;
    logic         stall;
    logic         ex_valid;
    logic [6:0]   ex_instr_id;
    logic [2:0]   ex_unit_id;
    logic [3:0]   ex_latency;
    logic         ex_reg_wr;
    logic [6:0]   ex_reg_dst;
    logic [17:0]  ex_imm;
    logic [9:0]   ex_pc;
    logic [127:0] ex_ra_data;
    logic [127:0] ex_rb_data;
    logic [127:0] ex_rc_data;

    modport master (
        output id_valid, id_instr_id, id_unit_id, id_latency, id_reg_wr, id_reg_dst,
               id_ra_addr, id_rb_addr, id_rc_addr, id_src_used, id_imm, id_pc,
        input  stall, ex_valid, ex_instr_id, ex_unit_id, ex_latency, ex_reg_wr,
               ex_reg_dst, ex_imm, ex_pc, ex_ra_data, ex_rb_data, ex_rc_data
    );

    modport slave (
        input  id_valid, id_instr_id, id_unit_id, id_latency, id_reg_wr, id_reg_dst,
               id_ra_addr, id_rb_addr, id_rc_addr, id_src_used, id_imm, id_pc,
        output stall, ex_valid, ex_instr_id, ex_unit_id, ex_latency, ex_reg_wr,
               ex_reg_dst, ex_imm, ex_pc, ex_ra_data, ex_rb_data, ex_rc_data
    );
endinterface

`default_nettype wire

// File: rtl/odd_rf_stage_operand_resolver.sv
// ============================================================================
//  Module   : operand_resolver
//  Purpose  : Resolves one source operand from the forwarding stages, the
//             write-back ports or the register file, and flags RAW hazards.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_resolver #(
    parameter int DATA_W     = 128,
    parameter int PACK_W     = 143,
    parameter int FWD_STAGES = 7,
    parameter int ADDR_W     = 7
) (
    input  wire logic [ADDR_W-1:0]           src_addr,
    input  wire logic                        src_used,
    input  wire logic [FWD_STAGES*PACK_W-1:0] even_fwd,
    input  wire logic [FWD_STAGES*PACK_W-1:0] odd_fwd,
    input  wire logic                        even_wb_en,
    input  wire logic [ADDR_W-1:0]           even_wb_addr,
    input  wire logic [DATA_W-1:0]           even_wb_data,
    input  wire logic                        odd_wb_en,
    input  wire logic [ADDR_W-1:0]           odd_wb_addr,
    input  wire logic [DATA_W-1:0]           odd_wb_data,
    input  wire logic [DATA_W-1:0]           rf_data,
    output logic      [DATA_W-1:0]           data,
    output logic                             hazard
);
    import odd_rf_stage_pkg::*;

    logic [DATA_W-1:0]             w_data;
    logic                          w_haz;
    logic [2*FWD_STAGES*3-1:0]     unused_unit_bits;

    always_comb begin
        logic [PACK_W-1:0] w_e;
        logic [PACK_W-1:0] w_o;
        w_e    = '0;
        w_o    = '0;
        w_data = rf_data;
        w_haz  = 1'b0;
        if (even_wb_en && (even_wb_addr == src_addr)) w_data = even_wb_data;
        if (odd_wb_en  && (odd_wb_addr  == src_addr)) w_data = odd_wb_data;
        // Oldest first so a younger match overrides; odd is checked after even in each stage.
        for (int k = FWD_STAGES; k >= 1; k--) begin
            w_e = even_fwd[(k-1)*PACK_W +: PACK_W];
            w_o = odd_fwd[(k-1)*PACK_W +: PACK_W];
            if (w_e[WR_BIT] && (w_e[DST_LO +: ADDR_W] == src_addr)) begin
                w_data = w_e[RES_LO +: DATA_W];
                w_haz  = !stage_ready(k, w_e[LAT_LO +: LAT_W]);
            end
            if (w_o[WR_BIT] && (w_o[DST_LO +: ADDR_W] == src_addr)) begin
                w_data = w_o[RES_LO +: DATA_W];
                w_haz  = !stage_ready(k, w_o[LAT_LO +: LAT_W]);
            end
        end
    end

    for (genvar k = 0; k < FWD_STAGES; k++) begin : g_unit_sink
        assign unused_unit_bits[k*6 +: 6] = {even_fwd[k*PACK_W + UNIT_LO +: 3],
                                             odd_fwd[k*PACK_W + UNIT_LO +: 3]};
    end

    assign data   = w_data;
    assign hazard = w_haz & src_used;

endmodule

`default_nettype wire

// File: rtl/odd_rf_stage.sv
// ============================================================================
//  Module   : odd_rf_stage
//  Purpose  : Odd-pipe register fetch: 128x128 RF, three-operand bypass,
//             RAW-hazard stall and registered odd-pipe input.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module odd_rf_stage #(
    parameter int NUM_REGS   = 128,
    parameter int DATA_W     = 128,
    parameter int PACK_W     = 143,
    parameter int FWD_STAGES = 7
) (
    input  wire logic                            clk,
    input  wire logic                            rst,
    odd_rf_stage_if.slave                        bus,
    input  wire logic [FWD_STAGES*PACK_W-1:0]    even_fwd,
    input  wire logic [FWD_STAGES*PACK_W-1:0]    odd_fwd,
    input  wire logic                            even_wb_en,
    input  wire logic [$clog2(NUM_REGS)-1:0]     even_wb_addr,
    input  wire logic [DATA_W-1:0]               even_wb_data,
    input  wire logic                            odd_wb_en,
    input  wire logic [$clog2(NUM_REGS)-1:0]     odd_wb_addr,
    input  wire logic [DATA_W-1:0]               odd_wb_data
);
    import odd_rf_stage_pkg::*;

    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];
    ex_word_t          ex_q;
    ex_word_t          ex_d;

    logic [6:0]        w_src_addr [3];
    logic [DATA_W-1:0] w_src_data [3];
    logic [2:0]        w_src_haz;
    logic              w_stall;

    assign w_src_addr[0] = bus.id_ra_addr;
    assign w_src_addr[1] = bus.id_rb_addr;
    assign w_src_addr[2] = bus.id_rc_addr;

    for (genvar i = 0; i < 3; i++) begin : g_src
        operand_resolver #(
            .DATA_W     (DATA_W),
            .PACK_W     (PACK_W),
            .FWD_STAGES (FWD_STAGES),
            .ADDR_W     ($clog2(NUM_REGS))
        ) u_resolver (
            .src_addr     (w_src_addr[i]),
            .src_used     (bus.id_src_used[i]),
            .even_fwd     (even_fwd),
            .odd_fwd      (odd_fwd),
            .even_wb_en   (even_wb_en),
            .even_wb_addr (even_wb_addr),
            .even_wb_data (even_wb_data),
            .odd_wb_en    (odd_wb_en),
            .odd_wb_addr  (odd_wb_addr),
            .odd_wb_data  (odd_wb_data),
            .rf_data      (rf_q[w_src_addr[i]]),
            .data         (w_src_data[i]),
            .hazard       (w_src_haz[i])
        );
    end

    assign w_stall = bus.id_valid & (|w_src_haz);

    // Odd write-back is applied last so it wins a same-address collision.
    always_comb begin
        rf_d = rf_q;
        if (even_wb_en) rf_d[even_wb_addr] = even_wb_data;
        if (odd_wb_en)  rf_d[odd_wb_addr]  = odd_wb_data;
    end

    always_comb begin
        ex_d = '0;
        if (bus.id_valid && !w_stall) begin
            ex_d.valid    = 1'b1;
            ex_d.instr_id = bus.id_instr_id;
            ex_d.unit_id  = bus.id_unit_id;
            ex_d.latency  = bus.id_latency;
            ex_d.reg_wr   = bus.id_reg_wr;
            ex_d.reg_dst  = bus.id_reg_dst;
            ex_d.imm      = bus.id_imm;
            ex_d.pc       = bus.id_pc;
            ex_d.ra_data  = w_src_data[0];
            ex_d.rb_data  = w_src_data[1];
            ex_d.rc_data  = w_src_data[2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
            ex_q <= '0;
        end else begin
            rf_q <= rf_d;
            ex_q <= ex_d;
        end
    end

    assign bus.stall       = w_stall;
    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_instr_id = ex_q.instr_id;
    assign bus.ex_unit_id  = ex_q.unit_id;
    assign bus.ex_latency  = ex_q.latency;
    assign bus.ex_reg_wr   = ex_q.reg_wr;
    assign bus.ex_reg_dst  = ex_q.reg_dst;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_ra_data  = ex_q.ra_data;
    assign bus.ex_rb_data  = ex_q.rb_data;
    assign bus.ex_rc_data  = ex_q.rc_data;

endmodule

`default_nettype wire
